sel_mux: RTL and testbench
==========================

# sel_mux

Two-input, N-bit selector with a registered output stage and a valid/ready handshake. Each accepted transfer captures either `a_i` or `b_i`, chosen by `sel_i`, into a one-entry output register. It sits at the datapath point where one of two same-width operands is forwarded downstream, and it isolates downstream timing from the select logic.

## Interface
Parameters:
- `N`, default 8: data width of `a_i`, `b_i` and `y_o`; legal range 1 to 64.

Ports:
- `clk_i`  input  1: single clock; all state updates on the rising edge.
- `rst_ni`  input  1: reset, asynchronous and active-low.
- `a_i`  input  N: operand A, selected when `sel_i`=0.
- `b_i`  input  N: operand B, selected when `sel_i`=1.
- `sel_i`  input  1: source select, 0→A, 1→B.
- `valid_i`  input  1: upstream presents `a_i`/`b_i`/`sel_i`.
- `ready_o`  output  1: stage can accept this cycle.
- `y_o`  output  N: registered selected data.
- `sel_o`  output  1: registered copy of the `sel_i` that produced `y_o`.
- `valid_o`  output  1: `y_o`/`sel_o` hold valid data.
- `ready_i`  input  1: downstream accepts `y_o` this cycle.

## Operation
- Accept condition: `valid_i && ready_o`.
- On accept, the registers load `y_q <= sel_i ? b_i : a_i` and `sel_q <= sel_i`, and set `valid_q` to 1.
- `ready_o = !valid_q || ready_i`. A full register can accept a new word in the same cycle its current word drains.
- Drain condition: `valid_o && ready_i`. If a drain occurs with no accept in the same cycle, `valid_q` goes to 0 and `y_q` keeps its last value.
- Simultaneous drain and accept: the new word replaces the old one and `valid_q` stays 1. No bubble is inserted.
- While `valid_q`=1 and `ready_i`=0, `y_o` and `sel_o` stay stable regardless of `a_i`, `b_i`, `sel_i` and `valid_i`.
- `sel_i`, `a_i` and `b_i` are ignored when `valid_i`=0.
- No arithmetic is performed. The selected operand passes bit-exact at width N with no extension or truncation.
- An unknown `sel_i` with `valid_i`=1 is a protocol error. A simulation assertion flags it.

## Timing
- Reset (async assert, sync-safe deassert): `valid_o`=0, `y_o`=0, `sel_o`=0, and `ready_o`=1 as soon as reset is asserted.
- Reset asserted mid-transfer discards the held word immediately. There is no partial-output state.
- Latency: a word accepted at edge k appears on `y_o` with `valid_o`=1 after edge k, i.e. one cycle.
- Throughput: one word per cycle while `ready_i`=1.
- `ready_o` is combinational from `valid_q` and `ready_i` only. There is no path from `a_i`, `b_i` or `sel_i` to any output.
- The first accept is possible in the first cycle after reset deasserts.

## Structure
- Shared package `mux_pkg`:
  - `localparam int unsigned MUX_DEFAULT_W = 8`.
  - Select encoding constants `SEL_A = 1'b0` and `SEL_B = 1'b1`.
  - `typedef enum logic {SRC_A, SRC_B} mux_src_e`.
- One sub-module: `mux2_comb`, a purely combinational N-bit 2:1 selector. `sel_mux` instantiates it ahead of the output register, and it can be reused elsewhere.
- Top-level assertions:
  - `valid_o` held while stalled.
  - `y_o` stable while stalled.
  - No X on `sel_i` when `valid_i`=1.

## Test plan
- Reset: drive `rst_ni`=0 mid-transfer with `valid_o`=1 → `valid_o`=0, `y_o`=8'h00, `ready_o`=1 immediately, before any clock edge.
- Select A: `a_i`=8'h3C, `b_i`=8'hA5, `sel_i`=0, `valid_i`=1, `ready_i`=1 → next cycle `y_o`=8'h3C, `sel_o`=0, `valid_o`=1.
- Select B: same operands with `sel_i`=1 → next cycle `y_o`=8'hA5, `sel_o`=1.
- Stall: with `ready_i`=0 and `valid_o`=1 holding 8'hA5, present `a_i`=8'hFF, `sel_i`=0 → `ready_o`=0 and `y_o` stays 8'hA5 for the whole stall; after `ready_i`=1 the next word is 8'hFF, then `ready_o`=1 again.
- Back-to-back: 10 random (`a_i`, `b_i`, `sel_i`) triples in consecutive cycles with `ready_i`=1 → 10 outputs with no bubbles, each equal to `sel ? b : a` and one cycle late.
- Width corner: set `N`=1, then `N`=16; run all-zeros/all-ones operands with both selects → exact pass-through with no truncation.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and types for the selector datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_W = 8;

  // Select encoding: 0 forwards operand A, 1 forwards operand B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {SRC_A, SRC_B} mux_src_e;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux2_comb.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_comb
//  Description : Purely combinational N-bit 2:1 selector (0 -> A, 1 -> B).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_comb
  import mux_pkg::*;
#(
  parameter int unsigned N = MUX_DEFAULT_W
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sel,
  output logic [N-1:0] o_y
);

  mux_src_e w_src;

  // Interpret the raw select bit as a source and forward that operand bit-exact.
  always_comb begin
    w_src = mux_src_e'(i_sel);
    o_y   = (w_src == SRC_B) ? i_b : i_a;
  end

endmodule : mux2_comb
`default_nettype wire

// File: rtl/sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sel_mux
//  Description : Two-input N-bit selector with a one-entry registered output
//                stage and valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_mux
  import mux_pkg::*;
#(
  parameter int unsigned N = MUX_DEFAULT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sel_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] y_o,
  output logic         sel_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [N-1:0] r_y;
  logic         r_sel;
  logic         r_valid;

  logic [N-1:0] w_y;
  logic         w_accept;
  logic         w_drain;

  // Selection happens ahead of the register so downstream sees only flop outputs.
  mux2_comb #(
    .N (N)
  ) u_mux2 (
    .i_a   (a_i),
    .i_b   (b_i),
    .i_sel (sel_i),
    .o_y   (w_y)
  );

  // Handshake decode: ready depends only on the held-valid flag and ready_i,
  // so a full stage can take a new word in the cycle its old word drains.
  always_comb begin
    ready_o  = !r_valid || ready_i;
    w_accept = valid_i && ready_o;
    w_drain  = r_valid && ready_i;
  end

  // One-entry output register; a drain without refill only clears valid,
  // leaving the last data in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_y     <= '0;
      r_sel   <= SEL_A;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_y     <= w_y;
      r_sel   <= sel_i;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign y_o     = r_y;
  assign sel_o   = r_sel;
  assign valid_o = r_valid;

`ifndef SYNTHESIS
  // A stalled word must stay presented and unchanged until it is taken.
  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> valid_o);

  a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> ($stable(y_o) && $stable(sel_o)));

  a_sel_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i |-> !$isunknown(sel_i));
`endif

endmodule : sel_mux
`default_nettype wire

// File: tb/tb_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sel_mux
//  Description : Scoreboard bench for sel_mux at widths 8, 1 and 16. The
//                three instances share handshake and select; data is sliced.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_w;
  logic [15:0] b_w;
  logic        sel;
  logic        vin;
  logic        rdy_in;

  logic        rdy8,  rdy1,  rdy16;
  logic [7:0]  y8;
  logic        y1;
  logic [15:0] y16;
  logic        s8,    s1,    s16;
  logic        v8,    v1,    v16;

  int total;
  int bad;

  logic [7:0]  q8[$];
  logic        q1[$];
  logic [15:0] q16[$];
  logic        qs[$];

  sel_mux #(.N(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a_w[7:0]), .b_i(b_w[7:0]), .sel_i(sel),
    .valid_i(vin), .ready_o(rdy8), .y_o(y8), .sel_o(s8), .valid_o(v8), .ready_i(rdy_in)
  );

  sel_mux #(.N(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a_w[0]), .b_i(b_w[0]), .sel_i(sel),
    .valid_i(vin), .ready_o(rdy1), .y_o(y1), .sel_o(s1), .valid_o(v1), .ready_i(rdy_in)
  );

  sel_mux #(.N(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a_w), .b_i(b_w), .sel_i(sel),
    .valid_i(vin), .ready_o(rdy16), .y_o(y16), .sel_o(s16), .valid_o(v16), .ready_i(rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whenever a word is presented and taken, pop and compare.
  always @(negedge clk) begin
    if (rst_n && v8 && rdy_in) begin
      if (q8.size() == 0) begin
        chk("unexpected_output", 16'd1, 16'd0);
      end else begin
        chk("y8",   {8'h00, y8},  {8'h00, q8.pop_front()});
        chk("y1",   {15'd0, y1},  {15'd0, q1.pop_front()});
        chk("y16",  y16,          q16.pop_front());
        chk("sel8", {15'd0, s8},  {15'd0, qs[0]});
        chk("sel16", {15'd0, s16}, {15'd0, qs.pop_front()});
        chk("valid_lockstep", {14'd0, v1, v16}, 16'h3);
      end
    end
  end

  // Present one word; holds valid until accepted and pushes the expected result.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit ok;
    a_w = a; b_w = b; sel = s; vin = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy8) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 16'd0, 16'd1);
    end else begin
      q8.push_back(s ? b[7:0] : a[7:0]);
      q1.push_back(s ? b[0] : a[0]);
      q16.push_back(s ? b : a);
      qs.push_back(s);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    vin = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] ta[10];
  logic [7:0] tb[10];
  logic       ts[10];
  time        t0;

  initial begin
    total = 0; bad = 0;
    a_w = '0; b_w = '0; sel = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    rst_n = 1'b0;
    ta = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h81};
    tb = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F, 8'hF0, 8'h18};
    ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("rst_valid", {15'd0, v8}, 16'd0);
    chk("rst_y",     {8'h00, y8}, 16'd0);
    chk("rst_ready", {15'd0, rdy8}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Select A, one-cycle latency, then empty after drain
    send(16'h003C, 16'h00A5, 1'b0);
    chk("lat_a_valid", {15'd0, v8}, 16'd1);
    chk("lat_a_y",     {8'h00, y8}, 16'h003C);
    idle();
    chk("drain_empty", {15'd0, v8}, 16'd0);
    chk("drain_keep_y", {8'h00, y8}, 16'h003C);

    // Select B
    send(16'h003C, 16'h00A5, 1'b1);
    chk("lat_b_y",   {8'h00, y8}, 16'h00A5);
    chk("lat_b_sel", {15'd0, s8}, 16'd1);
    idle();

    // Stall: A5 held while a new word waits
    rdy_in = 1'b0;
    send(16'h003C, 16'h00A5, 1'b1);
    a_w = 16'h00FF; b_w = 16'h00A5; sel = 1'b0; vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {15'd0, rdy8}, 16'd0);
      chk("stall_y",     {8'h00, y8},   16'h00A5);
      chk("stall_valid", {15'd0, v8},   16'd1);
      @(posedge clk);
    end
    #1;
    rdy_in = 1'b1;
    send(16'h00FF, 16'h00A5, 1'b0);
    chk("unstall_y", {8'h00, y8}, 16'h00FF);
    vin = 1'b0;
    @(negedge clk);
    chk("unstall_ready", {15'd0, rdy8}, 16'd1);
    @(posedge clk); #1;

    // Back-to-back: ten words, no bubbles
    t0 = $time;
    for (int i = 0; i < 10; i++) begin
      send({8'h5A, ta[i]}, {8'hC3, tb[i]}, ts[i]);
      chk("b2b_valid", {15'd0, v8}, 16'd1);
    end
    chk("b2b_cycles", 16'(($time - t0) / 10), 16'd10);
    idle();

    // Width corners: all-zeros / all-ones with both selects
    send(16'h0000, 16'hFFFF, 1'b0);
    send(16'h0000, 16'hFFFF, 1'b1);
    chk("wide_ones", y16, 16'hFFFF);
    send(16'hFFFF, 16'h0000, 1'b0);
    chk("narrow_one", {15'd0, y1}, 16'd1);
    send(16'hFFFF, 16'h0000, 1'b1);
    idle();

    // Reset mid-transfer discards a held word before any edge
    rdy_in = 1'b0;
    send(16'h1234, 16'h00EE, 1'b1);
    vin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {13'd0, v8, v1, v16}, 16'd0);
    chk("midrst_y",     y16, 16'd0);
    chk("midrst_ready", {13'd0, rdy8, rdy1, rdy16}, 16'h7);
    q8.pop_back(); q1.pop_back(); q16.pop_back(); qs.pop_back();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_in = 1'b1;

    for (int k = 0; k < 20; k++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_empty", 16'(q8.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sel_mux
`default_nettype wire
